// File: rtl/sr_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_arbiter_pkg
// Brief    : Shared types, defaults and SR command encoding for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sr_bank_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    localparam int C_N_REQ_DEFAULT = 4;
    localparam int C_WIDTH_DEFAULT = 8;

    // {s,r} command encoding for a single bank bit
    localparam logic [1:0] CMD_HOLD     = 2'b00;
    localparam logic [1:0] CMD_CLR      = 2'b01;
    localparam logic [1:0] CMD_SET      = 2'b10;
    localparam logic [1:0] CMD_CONFLICT = 2'b11;

    function automatic logic sr_bit(input logic [1:0] cmd, input logic cur);
        logic nxt;
        case (cmd)
            CMD_SET:  nxt = 1'b1;
            CMD_CLR:  nxt = 1'b0;
            CMD_HOLD,
            CMD_CONFLICT: nxt = cur;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_arbiter_if
// Brief    : Request/mask/grant bundle between requesters and the SR bank.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_bank_arbiter_if
    import sr_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT,
    parameter int WIDTH = C_WIDTH_DEFAULT
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] set_mask;
    logic [N_REQ*WIDTH-1:0] clr_mask;
    logic [N_REQ-1:0]       gnt;
    logic                   done;
    logic                   err;
    logic                   busy;
    logic [WIDTH-1:0]       q;

    modport master (
        output req, set_mask, clr_mask,
        input  gnt, done, err, busy, q
    );

    modport slave (
        input  req, set_mask, clr_mask,
        output gnt, done, err, busy, q
    );
endinterface
`default_nettype wire

// File: rtl/sr_bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin winner select starting at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import sr_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT,
    parameter int PTR_W = 2
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [N_REQ-1:0] winner,
    output logic      [PTR_W-1:0] idx,
    output logic                  valid
);

    logic w_found;

    assign valid = |req;

    // Walk upward from ptr with wrap; the first requester seen wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int               j;
            logic [PTR_W-1:0] j_idx;
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            j_idx = PTR_W'(j);
            if (!w_found && req[j_idx]) begin
                w_found       = 1'b1;
                winner[j_idx] = 1'b1;
                idx           = j_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_arbiter
// Brief    : Round-robin arbiter granting one requester at a time a SR bank update.
// Revision : 1.0 - initial release
// ============================================================================
module sr_bank_arbiter
    import sr_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT,
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sr_bank_arbiter_if.slave  bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_gnt,   w_gnt_nxt;
    logic [WIDTH-1:0]   r_set,   w_set_nxt;
    logic [WIDTH-1:0]   r_clr,   w_clr_nxt;
    logic [PTR_W-1:0]   r_idx,   w_idx_nxt;
    logic [PTR_W-1:0]   r_ptr,   w_ptr_nxt;
    logic [WIDTH-1:0]   r_q,     w_q_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_err,   w_err_nxt;

    logic [N_REQ-1:0]   w_win;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_win),
        .idx    (w_pick_idx),
        .valid  (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_set   <= '0;
            r_clr   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_set   <= w_set_nxt;
            r_clr   <= w_clr_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_set_nxt   = r_set;
        w_clr_nxt   = r_clr;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_any) begin
                    w_gnt_nxt   = w_win;
                    w_idx_nxt   = w_pick_idx;
                    w_state_nxt = APPLY;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (w_pick_idx == PTR_W'(i)) begin
                            w_set_nxt = bus.set_mask[i*WIDTH +: WIDTH];
                            w_clr_nxt = bus.clr_mask[i*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            APPLY: begin
                // Only the masks latched at grant time reach the bank.
                for (int b = 0; b < WIDTH; b++) begin
                    w_q_nxt[b] = sr_bit({r_set[b], r_clr[b]}, r_q[b]);
                end
                w_done_nxt  = 1'b1;
                w_err_nxt   = |(r_set & r_clr);
                w_ptr_nxt   = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // done/err are registered with q so they accompany the committed value.
    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.busy = (r_state == APPLY);
    assign bus.q    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_bank_arbiter
// Brief    : Directed self-checking bench for sr_bank_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_bank_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    sr_bank_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bif ();

    sr_bank_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.req = '0; bif.set_mask = '0; bif.clr_mask = '0;
        tick(); tick();
        checks++; if (bif.gnt  !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bif.gnt); end
        checks++; if (bif.done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", bif.done); end
        checks++; if (bif.err  !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", bif.err); end
        checks++; if (bif.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
        checks++; if (bif.q    !== 8'h00)   begin errors++; $display("FAIL reset_q: got %h want 00", bif.q); end
    endtask

    task automatic test_single();
        rst = 1'b1;
        bif.req = 4'b0001;
        bif.set_mask = {8'h00, 8'h00, 8'h00, 8'h0F};
        bif.clr_mask = '0;
        tick();
        checks++; if (bif.gnt  !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", bif.gnt); end
        checks++; if (bif.busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b want 1", bif.busy); end
        checks++; if (bif.q    !== 8'h00)   begin errors++; $display("FAIL single_q_early: got %h want 00", bif.q); end
        bif.req = 4'b0000;
        tick();
        checks++; if (bif.q    !== 8'h0F)   begin errors++; $display("FAIL single_q: got %h want 0f", bif.q); end
        checks++; if (bif.done !== 1'b1)    begin errors++; $display("FAIL single_done: got %b want 1", bif.done); end
        checks++; if (bif.err  !== 1'b0)    begin errors++; $display("FAIL single_err: got %b want 0", bif.err); end
        checks++; if (bif.gnt  !== 4'b0000) begin errors++; $display("FAIL single_gnt_clr: got %b want 0000", bif.gnt); end
        checks++; if (bif.busy !== 1'b0)    begin errors++; $display("FAIL single_busy_clr: got %b want 0", bif.busy); end
        tick();
        checks++; if (bif.done !== 1'b0)    begin errors++; $display("FAIL single_done_pulse: got %b want 0", bif.done); end
    endtask

    task automatic test_conflict();
        bif.req = 4'b0100;
        bif.set_mask = {8'h00, 8'hF0, 8'h00, 8'h00};
        bif.clr_mask = {8'h00, 8'h3C, 8'h00, 8'h00};
        tick();
        checks++; if (bif.gnt  !== 4'b0100) begin errors++; $display("FAIL conflict_gnt: got %b want 0100", bif.gnt); end
        bif.req = 4'b0000;
        tick();
        checks++; if (bif.q    !== 8'hC3)   begin errors++; $display("FAIL conflict_q: got %h want c3", bif.q); end
        checks++; if (bif.done !== 1'b1)    begin errors++; $display("FAIL conflict_done: got %b want 1", bif.done); end
        checks++; if (bif.err  !== 1'b1)    begin errors++; $display("FAIL conflict_err: got %b want 1", bif.err); end
        tick();
        checks++; if (bif.err  !== 1'b0)    begin errors++; $display("FAIL conflict_err_pulse: got %b want 0", bif.err); end
    endtask

    task automatic test_idle();
        bif.req = 4'b0000;
        bif.set_mask = '1;
        bif.clr_mask = '0;
        tick(); tick();
        checks++; if (bif.q   !== 8'hC3)   begin errors++; $display("FAIL idle_q: got %h want c3", bif.q); end
        checks++; if (bif.gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", bif.gnt); end
    endtask

    task automatic test_wrap();
        // pointer sits at 3 after serving index 2
        bif.req = 4'b0101;
        bif.set_mask = '0;
        bif.clr_mask = '0;
        tick();
        checks++; if (bif.gnt  !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b want 0001", bif.gnt); end
        tick();
        checks++; if (bif.done !== 1'b1)    begin errors++; $display("FAIL wrap_done: got %b want 1", bif.done); end
        checks++; if (bif.q    !== 8'hC3)   begin errors++; $display("FAIL wrap_hold_q: got %h want c3", bif.q); end
        tick();
        checks++; if (bif.gnt  !== 4'b0100) begin errors++; $display("FAIL wrap_second: got %b want 0100", bif.gnt); end
        bif.req = 4'b0000;
        tick();
        checks++; if (bif.done !== 1'b1)    begin errors++; $display("FAIL wrap_done2: got %b want 1", bif.done); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_q [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bif.req = 4'b1111;
        bif.set_mask = {8'h08, 8'h04, 8'h02, 8'h01};
        bif.clr_mask = '0;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++; if (bif.gnt !== exp_g[t]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", t, bif.gnt, exp_g[t]); end
            tick();
            checks++; if (bif.done !== 1'b1 || bif.gnt !== 4'b0000) begin errors++; $display("FAIL rr_done[%0d]: got done=%b gnt=%b want done=1 gnt=0000", t, bif.done, bif.gnt); end
            checks++; if (bif.q !== exp_q[t]) begin errors++; $display("FAIL rr_q[%0d]: got %h want %h", t, bif.q, exp_q[t]); end
        end
        bif.req = 4'b0000;
    endtask

    task automatic test_mask_change();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bif.req = 4'b0001;
        bif.set_mask = {8'h00, 8'h00, 8'h00, 8'h01};
        bif.clr_mask = '0;
        tick();
        checks++; if (bif.gnt !== 4'b0001) begin errors++; $display("FAIL mask_gnt: got %b want 0001", bif.gnt); end
        // winner drops req while another requester appears and all masks change
        bif.req = 4'b0010;
        bif.set_mask = '1;
        bif.clr_mask = '1;
        tick();
        checks++; if (bif.q    !== 8'h01) begin errors++; $display("FAIL mask_q: got %h want 01", bif.q); end
        checks++; if (bif.done !== 1'b1)  begin errors++; $display("FAIL mask_done: got %b want 1", bif.done); end
        checks++; if (bif.err  !== 1'b0)  begin errors++; $display("FAIL mask_err: got %b want 0", bif.err); end
        bif.req = 4'b0000;
        bif.set_mask = '0;
        bif.clr_mask = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        bif.req = 4'b0010;
        bif.set_mask = {8'h00, 8'h00, 8'hF0, 8'h00};
        tick();
        checks++; if (bif.gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt: got %b want 0010", bif.gnt); end
        rst = 1'b0;
        tick();
        checks++; if (bif.q    !== 8'h00)   begin errors++; $display("FAIL rmid_q: got %h want 00", bif.q); end
        checks++; if (bif.done !== 1'b0)    begin errors++; $display("FAIL rmid_done: got %b want 0", bif.done); end
        checks++; if (bif.gnt  !== 4'b0000) begin errors++; $display("FAIL rmid_gnt_clr: got %b want 0000", bif.gnt); end
        checks++; if (bif.busy !== 1'b0)    begin errors++; $display("FAIL rmid_busy: got %b want 0", bif.busy); end
        rst = 1'b1;
        bif.req = 4'b0011;
        bif.set_mask = {8'h00, 8'h00, 8'hF0, 8'h80};
        tick();
        checks++; if (bif.gnt !== 4'b0001) begin errors++; $display("FAIL rmid_ptr0: got %b want 0001", bif.gnt); end
        bif.req = 4'b0000;
        tick();
        checks++; if (bif.q    !== 8'h80) begin errors++; $display("FAIL rmid_q_after: got %h want 80", bif.q); end
        checks++; if (bif.done !== 1'b1)  begin errors++; $display("FAIL rmid_done_after: got %b want 1", bif.done); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req = '0;
        bif.set_mask = '0;
        bif.clr_mask = '0;
        test_reset();
        test_single();
        test_conflict();
        test_idle();
        test_wrap();
        test_round_robin();
        test_mask_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
